ps2_scancode_decoder: RTL and testbench

- Sits directly downstream of the PS/2 controller.
- Consumes its raw received byte stream (received_data / received_data_en) and assembles Set-2 scancode sequences (E0 extended prefix, F0 break prefix, E1 Pause sequence) into single key events.
- Buffers events in a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake to the consumer (CPU I/O port / keyboard MMIO).
- Filters device-status bytes and recovers from truncated prefix sequences by timeout.

---
 rtl/ps2_pkg.sv | 60 ++++++
 rtl/ps2_event_fifo.sv | 69 ++++++
 rtl/ps2_scancode_decoder.sv | 198 +++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 scancode decoder.
// Holds the decoder FSM state encoding, prefix/status byte values,
// modifier key scancodes and the queued key-event record.
package ps2_pkg;

  // Decoder FSM states.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GOT_E0     = 3'd1,
    ST_GOT_F0     = 3'd2,
    ST_GOT_E0_F0  = 3'd3,
    ST_PAUSE_SKIP = 3'd4
  } ps2_state_e;

  // Prefix bytes.
  localparam logic [7:0] BYTE_E0 = 8'hE0;  // extended prefix
  localparam logic [7:0] BYTE_F0 = 8'hF0;  // break prefix
  localparam logic [7:0] BYTE_E1 = 8'hE1;  // Pause sequence start

  // Device status / response bytes that never form a key event.
  localparam logic [7:0] BYTE_AA = 8'hAA;  // self-test passed
  localparam logic [7:0] BYTE_FA = 8'hFA;  // acknowledge
  localparam logic [7:0] BYTE_EE = 8'hEE;  // echo
  localparam logic [7:0] BYTE_FE = 8'hFE;  // resend
  localparam logic [7:0] BYTE_FC = 8'hFC;  // self-test failed
  localparam logic [7:0] BYTE_00 = 8'h00;  // key detection error
  localparam logic [7:0] BYTE_FF = 8'hFF;  // buffer overrun

  // Bytes following E1 in the 8-byte Pause sequence.
  localparam logic [2:0] PAUSE_SKIP_BYTES = 3'd7;

  // Modifier key scancodes.
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_LGUI   = 8'h1F;
  localparam logic [7:0] SC_RGUI   = 8'h27;

  // One decoded key event as stored in the event FIFO.
  typedef struct packed {
    logic [7:0] code;  // scancode with prefixes stripped
    logic       ext;   // E0 prefix seen
    logic       rel;   // F0 prefix seen (break)
  } ps2_event_t;

  localparam int EVENT_W = $bits(ps2_event_t);

  // True for bytes that report device status rather than a key.
  function automatic logic is_status_byte(input logic [7:0] b);
    logic r;
    case (b)
      BYTE_AA, BYTE_FA, BYTE_EE, BYTE_FE,
      BYTE_FC, BYTE_00, BYTE_FF: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic first-word-fall-through FIFO.
// rdata_o shows the head entry combinationally whenever empty_o is low.
// A push is accepted when not full, or when full and a pop happens in
// the same cycle; a pop is ignored when empty. Dropping and overflow
// reporting are left to the instantiating block.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are only observed through a valid head, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder.
// Turns the raw byte stream from the PS/2 controller into key events
// {code, ext, rel}, filters device status bytes, collapses the Pause
// sequence into one E1 event, abandons stalled prefix sequences after
// PREFIX_TIMEOUT cycles and queues events in an FWFT FIFO with a
// valid/ready consumer interface.
// Optional build macro: PS2_DECODER_MODIFIERS_EN enables held-modifier
// tracking on the modifiers output; otherwise modifiers is constant 0.
//
// Handshake: event_valid is high while the FIFO head holds an event and
// the head fields are stable until accepted; the head is consumed on a
// clock edge where event_valid and event_ready are both high.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [7:0] event_code,
  output logic       event_ext,
  output logic       event_release,
  output logic       overflow,
  output logic [3:0] modifiers
);

  localparam int TMO_W = $clog2(PREFIX_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PREFIX_TIMEOUT - 1);

  ps2_state_e       state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             overflow_q, overflow_d;

  logic             push_req;
  ps2_event_t       push_ev;
  ps2_event_t       head_ev;
  logic [EVENT_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             drop;

  // Decoder next state, timeout counter and event generation.
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    tmo_d    = tmo_q;
    push_req = 1'b0;
    push_ev  = '0;

    // Timeout: held at 0 in IDLE, cleared by any byte, otherwise counts
    // up and abandons the partial sequence on its last cycle.
    if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (received_data_en) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d   = '0;
      state_d = ST_IDLE;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (received_data_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (received_data == BYTE_E0) begin
            state_d = ST_GOT_E0;
          end else if (received_data == BYTE_F0) begin
            state_d = ST_GOT_F0;
          end else if (received_data == BYTE_E1) begin
            state_d = ST_PAUSE_SKIP;
            skip_d  = PAUSE_SKIP_BYTES;
          end else if (!is_status_byte(received_data)) begin
            push_req     = 1'b1;
            push_ev.code = received_data;
          end
        end
        ST_GOT_E0: begin
          if (received_data == BYTE_F0) begin
            state_d = ST_GOT_E0_F0;
          end else if (received_data != BYTE_E0) begin
            push_req     = 1'b1;
            push_ev.code = received_data;
            push_ev.ext  = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          push_req     = 1'b1;
          push_ev.code = received_data;
          push_ev.rel  = 1'b1;
          state_d      = ST_IDLE;
        end
        ST_GOT_E0_F0: begin
          push_req     = 1'b1;
          push_ev.code = received_data;
          push_ev.ext  = 1'b1;
          push_ev.rel  = 1'b1;
          state_d      = ST_IDLE;
        end
        ST_PAUSE_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            push_req     = 1'b1;
            push_ev.code = BYTE_E1;
            state_d      = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Decoder state registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
    end
  end

  assign pop        = event_valid && event_ready;
  assign drop       = push_req && fifo_full && !pop;
  assign overflow_d = overflow_q || drop;

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  ps2_event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .push_i  (push_req),
    .wdata_i (push_ev),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_ev       = fifo_empty ? '0 : ps2_event_t'(fifo_rdata);
  assign event_valid   = !fifo_empty;
  assign event_code    = head_ev.code;
  assign event_ext     = head_ev.ext;
  assign event_release = head_ev.rel;
  assign overflow      = overflow_q;

`ifdef PS2_DECODER_MODIFIERS_EN
  logic [3:0] mod_q, mod_d;
  logic       is_make;

  assign is_make = !push_ev.rel;

  // Held modifiers {gui, alt, ctrl, shift}, updated by every decoded
  // event (also dropped ones) except the Pause event.
  always_comb begin
    mod_d = mod_q;
    if (push_req && (state_q != ST_PAUSE_SKIP)) begin
      if (!push_ev.ext && (push_ev.code == SC_LSHIFT || push_ev.code == SC_RSHIFT))
        mod_d[0] = is_make;
      if (push_ev.code == SC_CTRL)
        mod_d[1] = is_make;
      if (push_ev.code == SC_ALT)
        mod_d[2] = is_make;
      if (push_ev.ext && (push_ev.code == SC_LGUI || push_ev.code == SC_RGUI))
        mod_d[3] = is_make;
    end
  end

  // Modifier state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) mod_q <= 4'b0000;
    else       mod_q <= mod_d;
  end

  assign modifiers = mod_q;
`else
  assign modifiers = 4'b0000;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with an expected-event queue.
// Build with or without PS2_DECODER_MODIFIERS_EN; expected modifier
// values follow the same macro.
`timescale 1ns/1ps
module tb_ps2_scancode_decoder;

  localparam int FIFO_DEPTH     = 4;
  localparam int PREFIX_TIMEOUT = 100;

`ifdef PS2_DECODER_MODIFIERS_EN
  localparam logic [3:0] MOD_SHIFT    = 4'b0001;
  localparam logic [3:0] MOD_SH_CTRL  = 4'b0011;
  localparam logic [3:0] MOD_CTRL     = 4'b0010;
`else
  localparam logic [3:0] MOD_SHIFT    = 4'b0000;
  localparam logic [3:0] MOD_SH_CTRL  = 4'b0000;
  localparam logic [3:0] MOD_CTRL     = 4'b0000;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       event_ready = 1'b0;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_ext;
  logic       event_release;
  logic       overflow;
  logic [3:0] modifiers;

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_scancode_decoder #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .PREFIX_TIMEOUT (PREFIX_TIMEOUT)
  ) dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .event_valid      (event_valid),
    .event_ready      (event_ready),
    .event_code       (event_code),
    .event_ext        (event_ext),
    .event_release    (event_release),
    .overflow         (overflow),
    .modifiers        (modifiers)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [7:0] c, input logic x, input logic r);
    check({tag, "_valid"}, 16'(event_valid), 16'd1);
    check({tag, "_head"}, 16'({event_code, event_ext, event_release}), 16'({c, x, r}));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLOCK_50); #1;
    received_data    = b;
    received_data_en = 1'b1;
    @(posedge CLOCK_50); #1;
    received_data_en = 1'b0;
  endtask

  // Strobe a byte in the same cycle the consumer accepts the head.
  task automatic send_byte_pop(input logic [7:0] b);
    @(posedge CLOCK_50); #1;
    received_data    = b;
    received_data_en = 1'b1;
    event_ready      = 1'b1;
    @(posedge CLOCK_50); #1;
    received_data_en = 1'b0;
    event_ready      = 1'b0;
  endtask

  task automatic expect_ev(input logic [7:0] c, input logic x, input logic r);
    exp_q.push_back({c, x, r});
  endtask

  task automatic pulse_reset();
    @(posedge CLOCK_50); #1;
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    int k;
    k = 0;
    event_ready = 1'b1;
    while ((exp_q.size() != 0 || event_valid) && k < max_cycles) begin
      @(posedge CLOCK_50); #1;
      k++;
    end
    event_ready = 1'b0;
    check({tag, "_queue_left"}, 16'(exp_q.size()), 16'd0);
    check({tag, "_valid_after"}, 16'(event_valid), 16'd0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge CLOCK_50) begin
    if (!reset && event_valid && event_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_event: observed %h expected none",
                 {event_code, event_ext, event_release});
        end
      end else begin
        check("event", 16'({event_code, event_ext, event_release}), 16'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    idle(3);
    check("rst_valid", 16'(event_valid), 16'd0);
    check("rst_code", 16'(event_code), 16'd0);
    check("rst_ext_rel", 16'({event_ext, event_release}), 16'd0);
    check("rst_overflow", 16'(overflow), 16'd0);
    check("rst_modifiers", 16'(modifiers), 16'd0);
    reset = 1'b0;
    idle(2);

    // Plain make, then break.
    event_ready = 1'b1;
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1C);
    check_head("make_1c", 8'h1C, 1'b0, 1'b0);
    send_byte(8'hF0);
    check("f0_no_event", 16'(event_valid), 16'd0);
    expect_ev(8'h1C, 1'b0, 1'b1);
    send_byte(8'h1C);
    check_head("break_1c", 8'h1C, 1'b0, 1'b1);

    // Extended make and break.
    send_byte(8'hE0);
    expect_ev(8'h75, 1'b1, 1'b0);
    send_byte(8'h75);
    check_head("ext_make", 8'h75, 1'b1, 1'b0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    check("e0f0_no_event", 16'(event_valid), 16'd0);
    expect_ev(8'h75, 1'b1, 1'b1);
    send_byte(8'h75);
    check_head("ext_break", 8'h75, 1'b1, 1'b1);

    // Status bytes are filtered.
    send_byte(8'hAA);
    send_byte(8'hFA);
    idle(2);
    check("status_filtered", 16'(event_valid), 16'd0);

    // Pause sequence yields one event after its 8th byte.
    send_byte(8'hE1);
    send_byte(8'h14);
    send_byte(8'h77);
    send_byte(8'hE1);
    send_byte(8'hF0);
    send_byte(8'h14);
    send_byte(8'hF0);
    check("pause_7_bytes", 16'(event_valid), 16'd0);
    expect_ev(8'hE1, 1'b0, 1'b0);
    send_byte(8'h77);
    check_head("pause_event", 8'hE1, 1'b0, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1C);
    check_head("after_pause", 8'h1C, 1'b0, 1'b0);

    // Gap shorter than the timeout keeps the break prefix.
    send_byte(8'hF0);
    idle(90);
    expect_ev(8'h1C, 1'b0, 1'b1);
    send_byte(8'h1C);
    check_head("short_gap", 8'h1C, 1'b0, 1'b1);

    // Gap longer than the timeout abandons the prefix.
    send_byte(8'hF0);
    idle(150);
    check("timeout_no_event", 16'(event_valid), 16'd0);
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1C);
    check_head("after_timeout", 8'h1C, 1'b0, 1'b0);

    // Modifier tracking.
    expect_ev(8'h12, 1'b0, 1'b0);
    send_byte(8'h12);
    check("mod_shift", 16'(modifiers), 16'(MOD_SHIFT));
    send_byte(8'hE0);
    expect_ev(8'h14, 1'b1, 1'b0);
    send_byte(8'h14);
    check("mod_ctrl", 16'(modifiers), 16'(MOD_SH_CTRL));
    send_byte(8'hF0);
    expect_ev(8'h12, 1'b0, 1'b1);
    send_byte(8'h12);
    check("mod_shift_rel", 16'(modifiers), 16'(MOD_CTRL));
    wait_drain("drain_basic", 20);

    // Overflow: five makes into a four-entry FIFO.
    expect_ev(8'h15, 1'b0, 1'b0);
    send_byte(8'h15);
    expect_ev(8'h16, 1'b0, 1'b0);
    send_byte(8'h16);
    expect_ev(8'h1D, 1'b0, 1'b0);
    send_byte(8'h1D);
    expect_ev(8'h1E, 1'b0, 1'b0);
    send_byte(8'h1E);
    check("full_no_overflow", 16'(overflow), 16'd0);
    check_head("full_head", 8'h15, 1'b0, 1'b0);
    send_byte(8'h24);
    check("overflow_set", 16'(overflow), 16'd1);
    check_head("head_stable", 8'h15, 1'b0, 1'b0);
    wait_drain("drain_overflow", 20);
    check("overflow_sticky", 16'(overflow), 16'd1);

    pulse_reset();
    check("overflow_cleared", 16'(overflow), 16'd0);
    check("reset_mods", 16'(modifiers), 16'd0);

    // Push with simultaneous pop while full is accepted.
    expect_ev(8'h15, 1'b0, 1'b0);
    send_byte(8'h15);
    expect_ev(8'h16, 1'b0, 1'b0);
    send_byte(8'h16);
    expect_ev(8'h1D, 1'b0, 1'b0);
    send_byte(8'h1D);
    expect_ev(8'h1E, 1'b0, 1'b0);
    send_byte(8'h1E);
    expect_ev(8'h2C, 1'b0, 1'b0);
    send_byte_pop(8'h2C);
    check("full_pushpop_overflow", 16'(overflow), 16'd0);
    check_head("full_pushpop_head", 8'h16, 1'b0, 1'b0);
    wait_drain("drain_pushpop", 20);

    // One entry with push and pop: new event becomes head.
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1C);
    expect_ev(8'h1D, 1'b0, 1'b0);
    send_byte_pop(8'h1D);
    check_head("one_entry_pushpop", 8'h1D, 1'b0, 1'b0);
    wait_drain("drain_one", 10);

    // Reset in the middle of an E0 F0 sequence with a queued event.
    send_byte(8'h12);
    send_byte(8'hE0);
    send_byte(8'hF0);
    pulse_reset();
    check("midseq_valid", 16'(event_valid), 16'd0);
    check("midseq_head", 16'({event_code, event_ext, event_release}), 16'd0);
    check("midseq_overflow", 16'(overflow), 16'd0);
    check("midseq_mods", 16'(modifiers), 16'd0);
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1C);
    check_head("after_midseq", 8'h1C, 1'b0, 1'b0);
    wait_drain("drain_final", 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
